// File: rtl/core_pkg.sv
// ============================================================================
//  Module      : core_pkg
//  Description : Shared encodings for the memory stage: access width codes
//                and the load/store unit state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    // Access width encodings carried on exmem_mem_width_i
    localparam logic [1:0] MW_BYTE = 2'b00;
    localparam logic [1:0] MW_HALF = 2'b01;
    localparam logic [1:0] MW_WORD = 2'b10;

    // Load/store unit state encoding
    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t LSU_IDLE  = 3'd0;
    localparam lsu_state_t LSU_REQ   = 3'd1;
    localparam lsu_state_t LSU_RESP  = 3'd2;
    localparam lsu_state_t LSU_DONE  = 3'd3;
    localparam lsu_state_t LSU_DRAIN = 3'd4;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational byte-lane logic for the load/store unit.
//                Generates store byte enables and replicated store data,
//                extracts and sign/zero-extends load data, and flags
//                misaligned or reserved-width accesses.
//  Ports       : addr_lo_i   - effective address bits [1:0]
//                width_i     - access width code (byte/half/word/reserved)
//                sdata_i     - raw store data from the pipeline
//                rdata_i     - raw word returned by the data bus
//                unsigned_i  - zero-extend loads when set
//                be_o        - byte enables for the bus
//                wdata_o     - lane-replicated store data
//                rdata_o     - aligned, extended load result
//                misalign_o  - access is misaligned or uses a reserved width
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  width_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    input  logic        unsigned_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] w_shifted;

    always_comb begin
        // Bring the addressed byte down to lane 0 before extension
        w_shifted  = rdata_i >> {addr_lo_i, 3'b000};
        be_o       = 4'b0000;
        wdata_o    = 32'h0;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;

        case (width_i)
            MW_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{sdata_i[7:0]}};
                rdata_o = {{24{~unsigned_i & w_shifted[7]}}, w_shifted[7:0]};
            end
            MW_HALF: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{sdata_i[15:0]}};
                rdata_o    = {{16{~unsigned_i & w_shifted[15]}}, w_shifted[15:0]};
            end
            MW_WORD: begin
                misalign_o = |addr_lo_i;
                be_o       = 4'b1111;
                wdata_o    = sdata_i;
                rdata_o    = rdata_i;
            end
            default: begin
                // Reserved width never reaches the bus
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
//  Module      : mem_lsu
//  Description : Memory-stage load/store unit. Runs the data-bus
//                request/grant/response handshake for loads and stores,
//                aligns byte lanes, stalls the pipeline until the access
//                completes and passes non-memory results and CSR writes
//                through to the MEM/WB register.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                exmem_*_i            - EX/MEM pipeline register outputs
//                fc_flush_mem_i       - kill the current memory op
//                bus_*                - data-bus request/grant/response
//                mem_reg_*_o          - register write toward MEM/WB
//                mem_csr_*_o          - CSR write pass-through
//                mem_stall_req_o      - stall request to flow controller
//                mem_misalign_o       - misaligned/reserved access flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] exmem_reg_wdata_i,
    input  logic [4:0]  exmem_reg_waddr_i,
    input  logic        exmem_reg_we_i,
    input  logic [31:0] exmem_csr_wdata_i,
    input  logic [11:0] exmem_csr_waddr_i,
    input  logic        exmem_csr_we_i,
    input  logic        exmem_mtype_i,
    input  logic        exmem_mem_rw_i,
    input  logic [1:0]  exmem_mem_width_i,
    input  logic [31:0] exmem_mem_sdata_i,
    input  logic        exmem_mem_unsigned_i,

    input  logic        fc_flush_mem_i,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,

    output logic [31:0] mem_reg_wdata_o,
    output logic [4:0]  mem_reg_waddr_o,
    output logic        mem_reg_we_o,
    output logic [31:0] mem_csr_wdata_o,
    output logic [11:0] mem_csr_waddr_o,
    output logic        mem_csr_we_o,
    output logic        mem_stall_req_o,
    output logic        mem_misalign_o
);

    lsu_state_t  state_q, state_d;
    logic [31:0] lbuf_q, lbuf_d;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_align_mis;
    logic        w_mis;
    logic        w_mem_ok;
    logic        w_load;
    logic        w_req;

    lsu_align u_align (
        .addr_lo_i  (exmem_reg_wdata_i[1:0]),
        .width_i    (exmem_mem_width_i),
        .sdata_i    (exmem_mem_sdata_i),
        .rdata_i    (bus_rdata_i),
        .unsigned_i (exmem_mem_unsigned_i),
        .be_o       (w_be),
        .wdata_o    (w_wdata),
        .rdata_o    (w_rdata),
        .misalign_o (w_align_mis)
    );

    // Width/alignment is only meaningful when a memory op is present
    assign w_mis    = exmem_mtype_i & w_align_mis;
    assign w_mem_ok = exmem_mtype_i & ~w_align_mis;
    assign w_load   = exmem_mtype_i & ~exmem_mem_rw_i;

    // ------------------------------------------------------------------
    // State and load buffer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            lbuf_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            lbuf_q  <= lbuf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lbuf_d  = lbuf_q;
        case (state_q)
            LSU_IDLE: begin
                if (w_mem_ok && !fc_flush_mem_i) begin
                    if (bus_gnt_i)
                        state_d = exmem_mem_rw_i ? LSU_DONE : LSU_RESP;
                    else
                        state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (bus_gnt_i) begin
                    // A granted access is issued even if flushed: a load
                    // still owes a response that must be drained.
                    if (fc_flush_mem_i)
                        state_d = exmem_mem_rw_i ? LSU_IDLE : LSU_DRAIN;
                    else
                        state_d = exmem_mem_rw_i ? LSU_DONE : LSU_RESP;
                end else if (fc_flush_mem_i) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_RESP: begin
                if (bus_rvalid_i) begin
                    // Response arriving with a flush completes the read;
                    // nothing is left outstanding, so no drain is needed.
                    if (fc_flush_mem_i) begin
                        state_d = LSU_IDLE;
                    end else begin
                        lbuf_d  = w_rdata;
                        state_d = LSU_DONE;
                    end
                end else if (fc_flush_mem_i) begin
                    state_d = LSU_DRAIN;
                end
            end
            LSU_DRAIN: begin
                if (bus_rvalid_i)
                    state_d = LSU_IDLE;
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_req           = 1'b0;
        mem_stall_req_o = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                w_req           = w_mem_ok & ~fc_flush_mem_i;
                mem_stall_req_o = w_mem_ok;
            end
            LSU_REQ: begin
                w_req           = 1'b1;
                mem_stall_req_o = w_mem_ok;
            end
            LSU_RESP: begin
                mem_stall_req_o = w_mem_ok;
            end
            LSU_DRAIN: begin
                // Only hold the pipe if a new memory op is queued behind
                // the read being drained.
                mem_stall_req_o = w_mem_ok;
            end
            default: begin
                w_req           = 1'b0;
                mem_stall_req_o = 1'b0;
            end
        endcase

        bus_req_o   = w_req;
        bus_we_o    = w_req & exmem_mem_rw_i;
        bus_addr_o  = w_req ? {exmem_reg_wdata_i[31:2], 2'b00} : 32'h0;
        bus_be_o    = w_req ? w_be : 4'b0000;
        bus_wdata_o = (w_req && exmem_mem_rw_i) ? w_wdata : 32'h0;

        mem_reg_wdata_o = w_load ? lbuf_q : exmem_reg_wdata_i;
        mem_reg_waddr_o = exmem_reg_waddr_i;
        mem_reg_we_o    = exmem_reg_we_i & ~w_mis
                          & ~(w_load & (state_q != LSU_DONE));
        mem_csr_wdata_o = exmem_csr_wdata_i;
        mem_csr_waddr_o = exmem_csr_waddr_i;
        mem_csr_we_o    = exmem_csr_we_i;
        mem_misalign_o  = w_mis;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu: table-driven single-cycle
//                vectors, hand-written multi-cycle sequences and randomized
//                transactions checked against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] exmem_reg_wdata_i;
    logic [4:0]  exmem_reg_waddr_i;
    logic        exmem_reg_we_i;
    logic [31:0] exmem_csr_wdata_i;
    logic [11:0] exmem_csr_waddr_i;
    logic        exmem_csr_we_i;
    logic        exmem_mtype_i;
    logic        exmem_mem_rw_i;
    logic [1:0]  exmem_mem_width_i;
    logic [31:0] exmem_mem_sdata_i;
    logic        exmem_mem_unsigned_i;
    logic        fc_flush_mem_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] mem_reg_wdata_o;
    logic [4:0]  mem_reg_waddr_o;
    logic        mem_reg_we_o;
    logic [31:0] mem_csr_wdata_o;
    logic [11:0] mem_csr_waddr_o;
    logic        mem_csr_we_o;
    logic        mem_stall_req_o;
    logic        mem_misalign_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .exmem_reg_wdata_i    (exmem_reg_wdata_i),
        .exmem_reg_waddr_i    (exmem_reg_waddr_i),
        .exmem_reg_we_i       (exmem_reg_we_i),
        .exmem_csr_wdata_i    (exmem_csr_wdata_i),
        .exmem_csr_waddr_i    (exmem_csr_waddr_i),
        .exmem_csr_we_i       (exmem_csr_we_i),
        .exmem_mtype_i        (exmem_mtype_i),
        .exmem_mem_rw_i       (exmem_mem_rw_i),
        .exmem_mem_width_i    (exmem_mem_width_i),
        .exmem_mem_sdata_i    (exmem_mem_sdata_i),
        .exmem_mem_unsigned_i (exmem_mem_unsigned_i),
        .fc_flush_mem_i       (fc_flush_mem_i),
        .bus_req_o            (bus_req_o),
        .bus_we_o             (bus_we_o),
        .bus_addr_o           (bus_addr_o),
        .bus_be_o             (bus_be_o),
        .bus_wdata_o          (bus_wdata_o),
        .bus_gnt_i            (bus_gnt_i),
        .bus_rvalid_i         (bus_rvalid_i),
        .bus_rdata_i          (bus_rdata_i),
        .mem_reg_wdata_o      (mem_reg_wdata_o),
        .mem_reg_waddr_o      (mem_reg_waddr_o),
        .mem_reg_we_o         (mem_reg_we_o),
        .mem_csr_wdata_o      (mem_csr_wdata_o),
        .mem_csr_waddr_o      (mem_csr_waddr_o),
        .mem_csr_we_o         (mem_csr_we_o),
        .mem_stall_req_o      (mem_stall_req_o),
        .mem_misalign_o       (mem_misalign_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] w, input logic uns);
        longint v;
        longint span;
        v = longint'(rd) >> (8 * off);
        if (nbytes(w) == 4) return rd;
        span = longint'(1) << (8 * nbytes(w));
        v = v % span;
        if (!uns && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] off, input logic [1:0] w);
        return 4'(((1 << nbytes(w)) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [1:0] w);
        if (w == 2'd0) return {24'h0, sd[7:0]} * 32'h01010101;
        if (w == 2'd1) return {16'h0, sd[15:0]} * 32'h00010001;
        return sd;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input logic mt, input logic rw, input logic [1:0] w,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic uns, input logic rwe);
        exmem_mtype_i        = mt;
        exmem_mem_rw_i       = rw;
        exmem_mem_width_i    = w;
        exmem_reg_wdata_i    = addr;
        exmem_mem_sdata_i    = sd;
        exmem_mem_unsigned_i = uns;
        exmem_reg_we_i       = rwe;
        exmem_reg_waddr_i    = 5'd7;
    endtask

    task automatic nop();
        set_op(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        fc_flush_mem_i = 1'b0;
    endtask

    // Runs one memory op from IDLE; called and returns at a negedge.
    task automatic run_op(input logic rw, input logic [1:0] w, input logic [31:0] addr,
                          input logic [31:0] sd, input logic uns, input logic [31:0] rdata,
                          input int gd, input int rd, output logic [31:0] res);
        int  stalls = 0, reqs = 0, rcnt = 0;
        bit  granted = 0, got = 0, fin = 0;
        logic [31:0] exp_res;
        exp_res = rw ? addr : ref_load(rdata, addr[1:0], w, uns);
        res = 32'h0;
        set_op(1'b1, rw, w, addr, sd, uns, ~rw);
        for (int c = 0; c < 40 && !fin; c++) begin
            #1;
            if (granted && (rw || got)) begin
                chk("done_stall", {31'h0, mem_stall_req_o}, 32'h0);
                chk("done_we", {31'h0, mem_reg_we_o}, {31'h0, ~rw});
                chk("done_wdata", mem_reg_wdata_o, exp_res);
                res = mem_reg_wdata_o;
                fin = 1;
                nop();
            end else begin
                if (mem_stall_req_o) stalls++;
                if (!rw) chk("load_we_low", {31'h0, mem_reg_we_o}, 32'h0);
                if (bus_req_o) begin
                    chk("bus_addr", bus_addr_o, addr & ~32'h3);
                    chk("bus_be", {28'h0, bus_be_o}, {28'h0, ref_be(addr[1:0], w)});
                    chk("bus_we", {31'h0, bus_we_o}, {31'h0, rw});
                    if (rw) chk("bus_wdata", bus_wdata_o, ref_wdata(sd, w));
                    bus_gnt_i = (reqs == gd);
                    reqs++;
                end
                if (granted && !rw) begin
                    bus_rvalid_i = (rcnt == rd);
                    bus_rdata_i  = bus_rvalid_i ? rdata : $urandom;
                    rcnt++;
                end
            end
            @(posedge clk);
            if (bus_gnt_i) granted = 1;
            if (bus_rvalid_i) got = 1;
            @(negedge clk);
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
        end
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL op_timeout: got no completion expected completion within 40 cycles");
            nop();
        end
        chk("stall_cycles", stalls, rw ? 1 + gd : 2 + gd + rd);
    endtask

    // ---------------- single-cycle vector table ----------------
    typedef struct {
        logic        mt, rw, flush, rwe, uns;
        logic [1:0]  w;
        logic [31:0] addr, sd;
        logic        ereq;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        emis, estall, ewe;
        logic [31:0] eout;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] r;
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h1234, 32'h0,
                    1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h203, 32'hA5,
                    1'b1, 4'h8, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'h203};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h102, 32'hBEEF1234,
                    1'b1, 4'hC, 32'h12341234, 1'b0, 1'b1, 1'b0, 32'h102};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h104, 32'hCAFEF00D,
                    1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h104};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h101, 32'h0,
                    1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h102, 32'h0,
                    1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 32'h100, 32'h0,
                    1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h200, 32'h77,
                    1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h003, 32'h0,
                    1'b1, 4'h8, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h206, 32'h0000ABCD,
                    1'b1, 4'hC, 32'hABCDABCD, 1'b0, 1'b1, 1'b0, 32'h206};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h010, 32'h5,
                    1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h010};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
        exmem_csr_wdata_i = 32'h0; exmem_csr_waddr_i = 12'h0; exmem_csr_we_i = 1'b0;
        nop();
        exmem_reg_waddr_i = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_bus", {bus_req_o, bus_we_o, bus_be_o, 26'h0}, 32'h0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_bus_wdata", bus_wdata_o, 32'h0);
        chk("rst_mem", {mem_reg_we_o, mem_stall_req_o, mem_misalign_o, mem_csr_we_o, 28'h0}, 32'h0);
        chk("rst_reg_wdata", mem_reg_wdata_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table vectors (all from IDLE) ----------------
        for (int i = 0; i < 11; i++) begin
            set_op(tbl[i].mt, tbl[i].rw, tbl[i].w, tbl[i].addr, tbl[i].sd, tbl[i].uns, tbl[i].rwe);
            fc_flush_mem_i    = tbl[i].flush;
            exmem_csr_wdata_i = 32'hC0000000 | i;
            exmem_csr_waddr_i = 12'(i + 'h300);
            exmem_csr_we_i    = i[0];
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, bus_req_o}, {31'h0, tbl[i].ereq});
            chk($sformatf("v%0d_addr", i), bus_addr_o, tbl[i].ereq ? (tbl[i].addr & ~32'h3) : 32'h0);
            chk($sformatf("v%0d_be", i), {28'h0, bus_be_o}, {28'h0, tbl[i].ebe});
            chk($sformatf("v%0d_wdata", i), bus_wdata_o, tbl[i].ewd);
            chk($sformatf("v%0d_mis", i), {31'h0, mem_misalign_o}, {31'h0, tbl[i].emis});
            chk($sformatf("v%0d_stall", i), {31'h0, mem_stall_req_o}, {31'h0, tbl[i].estall});
            chk($sformatf("v%0d_we", i), {31'h0, mem_reg_we_o}, {31'h0, tbl[i].ewe});
            chk($sformatf("v%0d_out", i), mem_reg_wdata_o, tbl[i].eout);
            chk($sformatf("v%0d_waddr", i), {27'h0, mem_reg_waddr_o}, 32'd7);
            chk($sformatf("v%0d_csr", i), mem_csr_wdata_o, 32'hC0000000 | i);
            chk($sformatf("v%0d_csra", i), {20'h0, mem_csr_waddr_o}, 32'(i + 'h300));
            chk($sformatf("v%0d_csrwe", i), {31'h0, mem_csr_we_o}, {31'h0, i[0]});
            nop();
            @(negedge clk);
        end

        // ---------------- directed multi-cycle sequences ----------------
        run_op(1'b0, 2'd2, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0, r);
        chk("lw_100", r, 32'hDEADBEEF);
        run_op(1'b1, 2'd0, 32'h203, 32'hA5, 1'b0, 32'h0, 2, 0, r);
        run_op(1'b0, 2'd0, 32'h2, 32'h0, 1'b0, 32'h0080FF00, 1, 1, r);
        chk("lb_2", r, 32'hFFFFFF80);
        run_op(1'b0, 2'd0, 32'h2, 32'h0, 1'b1, 32'h0080FF00, 0, 2, r);
        chk("lbu_2", r, 32'h00000080);
        run_op(1'b0, 2'd1, 32'h2, 32'h0, 1'b0, 32'h0080FF00, 0, 0, r);
        chk("lh_2", r, 32'h00000080);
        run_op(1'b0, 2'd1, 32'h0, 32'h0, 1'b0, 32'h0080FF00, 0, 0, r);
        chk("lh_0_neg", r, 32'hFFFFFF00);

        // Flush in RESP: drain, discard, then a new load issues after the drain
        set_op(1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, 1'b1);
        #1; chk("dr_req", {31'h0, bus_req_o}, 32'h1);
        bus_gnt_i = 1'b1;
        @(posedge clk); @(negedge clk); bus_gnt_i = 1'b0;
        #1; chk("dr_resp_stall", {31'h0, mem_stall_req_o}, 32'h1);
        fc_flush_mem_i = 1'b1;
        @(posedge clk); @(negedge clk); nop();
        #1; chk("dr_stall_drop", {30'h0, mem_stall_req_o, bus_req_o}, 32'h0);
        @(posedge clk); @(negedge clk);
        set_op(1'b1, 1'b0, 2'd2, 32'h80, 32'h0, 1'b0, 1'b1);
        #1; chk("dr_wait_stall", {30'h0, mem_stall_req_o, bus_req_o}, 32'h2);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0BAD0;
        @(posedge clk); @(negedge clk); bus_rvalid_i = 1'b0;
        run_op(1'b0, 2'd2, 32'h80, 32'h0, 1'b0, 32'h11223344, 0, 0, r);
        chk("dr_next_lw", r, 32'h11223344);

        // Flush together with grant in REQ: load goes to DRAIN
        set_op(1'b1, 1'b0, 2'd2, 32'h300, 32'h0, 1'b0, 1'b1);
        @(posedge clk); @(negedge clk);
        #1; chk("fg_req_held", {31'h0, bus_req_o}, 32'h1);
        bus_gnt_i = 1'b1; fc_flush_mem_i = 1'b1;
        @(posedge clk); @(negedge clk); bus_gnt_i = 1'b0; nop();
        #1; chk("fg_drain", {30'h0, mem_stall_req_o, bus_req_o}, 32'h0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0;
        @(posedge clk); @(negedge clk); bus_rvalid_i = 1'b0;
        run_op(1'b1, 2'd2, 32'h304, 32'h55, 1'b0, 32'h0, 0, 0, r);

        // ---------------- randomized transactions ----------------
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  w;
            logic [31:0] a;
            w = 2'($urandom_range(0, 2));
            a = $urandom & ~32'(nbytes(w) - 1);
            run_op(1'($urandom_range(0, 1)), w, a, $urandom, 1'($urandom_range(0, 1)),
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 3), r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs and runs the data-bus request/grant/response handshake for loads and stores. It aligns byte lanes for both directions and asks the flow controller to stall the pipeline until the access completes. Non-memory instructions, and CSR writes, pass through unchanged toward the MEM/WB register.

## Interface
- No parameters; data/address width fixed at 32.
- Clock and reset: clk input, rst_n input 1 (reset rst_n, asynchronous, active-low; clock clk).
- exmem_reg_wdata_i in 32: ALU result; effective address when exmem_mtype_i=1.
- exmem_reg_waddr_i in 5 / exmem_reg_we_i in 1: destination register and write enable.
- exmem_csr_wdata_i in 32 / exmem_csr_waddr_i in 12 / exmem_csr_we_i in 1: CSR write, passed through.
- exmem_mtype_i in 1: memory op present.
- exmem_mem_rw_i in 1: 0 = load, 1 = store.
- exmem_mem_width_i in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- exmem_mem_sdata_i in 32: store data. exmem_mem_unsigned_i in 1: zero-extend load.
- fc_flush_mem_i in 1: kill the current op.
- bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32 (word aligned, [1:0]=00), bus_be_o out 4, bus_wdata_o out 32.
- bus_gnt_i in 1, bus_rvalid_i in 1, bus_rdata_i in 32.
- mem_reg_wdata_o out 32, mem_reg_waddr_o out 5, mem_reg_we_o out 1: to MEM/WB.
- mem_csr_wdata_o out 32, mem_csr_waddr_o out 12, mem_csr_we_o out 1: pass-through.
- mem_stall_req_o out 1: to flow controller; holds IF..EX/MEM while high.
- mem_misalign_o out 1: misaligned/reserved access; no bus traffic.

## Operation
- States: IDLE, REQ, RESP, DONE, DRAIN. Reset: IDLE, load buffer 0.
- IDLE:
  - bus_req_o = mtype & ~misalign & ~flush.
  - On gnt: store -> DONE, load -> RESP. No gnt -> REQ.
- REQ: bus_req_o held, address/be/wdata stable.
  - gnt: store -> DONE, load -> RESP.
  - flush without gnt -> IDLE; request dropped.
- RESP: waits for rvalid. On rvalid, lane-extract rdata into the load buffer and go to DONE. Flush -> DRAIN.
- DRAIN: no stall. Waits for rvalid, discards the data, then -> IDLE. bus_req_o=0 while in DRAIN.
- DONE: stall released; load buffer drives mem_reg_wdata_o. Unconditionally -> IDLE, picking up the new EX/MEM contents the next cycle.
- Stall: mem_stall_req_o = mtype & ~misalign & state∉{DONE,DRAIN}.
  - Also high in DRAIN only if a new memory op is waiting.
- Misalign conditions: half with addr[0]=1, word with addr[1:0]≠0, width 11. Result: mem_misalign_o=1, mem_reg_we_o=0, no stall.
- Store lanes:
  - byte: be = 0001<<addr[1:0], wdata = {4{sdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{sdata[15:0]}}.
  - word: be = 1111.
- Load extract: rdata >> 8*addr[1:0], then sign- or zero-extend from 8/16 bits per unsigned_i.
- Outputs:
  - mem_reg_wdata_o = load ? buffer : exmem_reg_wdata_i.
  - mem_reg_we_o = exmem_reg_we_i & ~misalign & ~(load & state≠DONE).
  - mem_reg_waddr_o and the CSR outputs pass through combinationally.

## Timing
- All bus outputs are combinational from state + EX/MEM inputs; state and load buffer are registered.
- Bus outputs are 0 in reset. All outputs are 0 after reset, since EX/MEM resets to 0.
- Best case, store: 2 cycles (IDLE with gnt, DONE).
- Best case, load: 3 cycles (IDLE with gnt, RESP with rvalid, DONE). Each gnt/rvalid wait cycle adds 1.
- rvalid never arrives in the gnt cycle; at most one outstanding read.
- Flush and gnt in the same cycle: the access counts as issued. Store -> IDLE, load -> DRAIN.
- Reset mid-access: immediate IDLE. The bus agent is reset with the core.

## Structure
- Shared package core_pkg: width encodings MW_BYTE/MW_HALF/MW_WORD, LSU state encoding.
- One combinational sub-module, lsu_align: store be/wdata generation, load extract/extend, misalign detect.
- The FSM and load buffer live in mem_lsu.

## Test plan
- lw addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> stall high 2 cycles; DONE gives mem_reg_wdata_o=0xDEADBEEF, we=1.
- sb addr 0x203, sdata 0x000000A5, gnt delayed 2 cycles -> bus_addr 0x200, be 1000, wdata 0xA5A5A5A5, stall 3 cycles.
- lb/lbu addr 0x2, rdata 0x0080FF00 -> 0xFFFFFF80 / 0x00000080. lh addr 0x2 -> 0x00000080.
- lh addr 0x101 -> mem_misalign_o=1, bus_req_o=0, mem_reg_we_o=0, no stall.
- Load granted, flush in RESP -> stall drops, DRAIN; later rvalid is discarded. A following lw issues only after the drain.
- Non-memory op: reg_wdata 0x1234, csr_we=1 -> pass-through in the same cycle, no stall, bus idle.
